// File: rtl/apb_master_if.sv
// Bundles the local command/response port and the APB bus of apb_master.
// The master modport is the bridge's view; slave is the requester/slave side.
interface apb_master_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              psel_x;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
        output cmd_ready, psel_x, penable, pwrite, paddr, pwdata,
               rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
        input  cmd_ready, psel_x, penable, pwrite, paddr, pwdata,
               rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: turns one local command into an APB
// SETUP/ACCESS transfer and returns a one-cycle response, with optional timeout.
module apb_master #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic          pclk,
    input  logic          preset_n,
    apb_master_if.master  bus
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              pwrite_q, pwrite_next;
    logic [ADDR_W-1:0] paddr_q, paddr_next;
    logic [DATA_W-1:0] pwdata_q, pwdata_next;
    logic              rsp_valid_q, rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_next;
    logic              rsp_err_q, rsp_err_next;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state       <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_next;
            pwrite_q    <= pwrite_next;
            paddr_q     <= paddr_next;
            pwdata_q    <= pwdata_next;
            rsp_valid_q <= rsp_valid_next;
            rsp_rdata_q <= rsp_rdata_next;
            rsp_err_q   <= rsp_err_next;
            wait_cnt    <= wait_cnt_next;
        end
    end

    // Completion is tested before the timeout so a late pready still wins the tie.
    always_comb begin
        state_next     = state;
        pwrite_next    = pwrite_q;
        paddr_next     = paddr_q;
        pwdata_next    = pwdata_q;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_q;
        rsp_err_next   = rsp_err_q;
        wait_cnt_next  = wait_cnt;

        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_next    = SETUP;
                    pwrite_next   = bus.cmd_write;
                    paddr_next    = bus.cmd_addr;
                    pwdata_next   = bus.cmd_wdata;
                    wait_cnt_next = '0;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = pwrite_q ? '0 : bus.prdata;
                end else if ((TIMEOUT > 0) && (wait_cnt == TMO_LAST)) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '0;
                end else if (TIMEOUT > 0) begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.psel_x    = (state != IDLE);
    assign bus.penable   = (state == ACCESS);
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: default, TIMEOUT=4 and TIMEOUT=2 instances
// share clock and reset; expected values are hand-computed per cycle.
module tb_apb_master;

    logic pclk;
    logic preset_n;

    int testsRun  = 0;
    int testsFail = 0;

    apb_master_if #(.DATA_W(8), .ADDR_W(2)) b0 ();
    apb_master_if #(.DATA_W(8), .ADDR_W(2)) b4 ();
    apb_master_if #(.DATA_W(8), .ADDR_W(2)) b2 ();

    apb_master #(.DATA_W(8), .ADDR_W(2), .TIMEOUT(15)) u0 (.pclk(pclk), .preset_n(preset_n), .bus(b0));
    apb_master #(.DATA_W(8), .ADDR_W(2), .TIMEOUT(4))  u4 (.pclk(pclk), .preset_n(preset_n), .bus(b4));
    apb_master #(.DATA_W(8), .ADDR_W(2), .TIMEOUT(2))  u2 (.pclk(pclk), .preset_n(preset_n), .bus(b2));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic wr, input logic [1:0] addr, input logic [7:0] wdata);
        b0.cmd_valid = valid;
        b0.cmd_write = wr;
        b0.cmd_addr  = addr;
        b0.cmd_wdata = wdata;
    endtask

    initial begin
        b0.cmd_valid = 0; b0.cmd_write = 0; b0.cmd_addr = 0; b0.cmd_wdata = 0; b0.pready = 0; b0.prdata = 0;
        b4.cmd_valid = 0; b4.cmd_write = 0; b4.cmd_addr = 0; b4.cmd_wdata = 0; b4.pready = 0; b4.prdata = 0;
        b2.cmd_valid = 0; b2.cmd_write = 0; b2.cmd_addr = 0; b2.cmd_wdata = 0; b2.pready = 0; b2.prdata = 0;
        preset_n = 1'b0;
        repeat (3) tick();
        checkOutput("rst_cmd_ready", b0.cmd_ready, 1);
        checkOutput("rst_psel", b0.psel_x, 0);
        checkOutput("rst_penable", b0.penable, 0);
        checkOutput("rst_paddr", b0.paddr, 0);
        checkOutput("rst_pwdata", b0.pwdata, 0);
        checkOutput("rst_rsp_valid", b0.rsp_valid, 0);
        @(negedge pclk);
        preset_n = 1'b1;
        tick();

        // Write with immediate pready
        applyStimulus(1, 1, 2'd2, 8'h1F);
        b0.pready = 1;
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("wr_setup_psel", b0.psel_x, 1);
        checkOutput("wr_setup_penable", b0.penable, 0);
        checkOutput("wr_setup_paddr", b0.paddr, 2);
        checkOutput("wr_setup_pwdata", b0.pwdata, 8'h1F);
        checkOutput("wr_setup_pwrite", b0.pwrite, 1);
        checkOutput("wr_setup_cmd_ready", b0.cmd_ready, 0);
        tick();
        checkOutput("wr_access_penable", b0.penable, 1);
        checkOutput("wr_access_psel", b0.psel_x, 1);
        tick();
        checkOutput("wr_rsp_valid", b0.rsp_valid, 1);
        checkOutput("wr_rsp_err", b0.rsp_err, 0);
        checkOutput("wr_rsp_rdata", b0.rsp_rdata, 0);
        checkOutput("wr_cmd_ready", b0.cmd_ready, 1);
        checkOutput("wr_idle_psel", b0.psel_x, 0);
        checkOutput("wr_idle_paddr_kept", b0.paddr, 2);
        b0.pready = 0;
        tick();
        checkOutput("wr_rsp_pulse_end", b0.rsp_valid, 0);

        // Read with three wait states
        applyStimulus(1, 0, 2'd1, 8'h00);
        tick();
        applyStimulus(0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rd_access%0d_penable", i), b0.penable, 1);
            checkOutput($sformatf("rd_access%0d_paddr", i), b0.paddr, 1);
            if (i == 3) begin
                b0.pready = 1;
                b0.prdata = 8'hA5;
            end
            tick();
        end
        b0.pready = 0;
        b0.prdata = 8'h00;
        checkOutput("rd_rsp_valid", b0.rsp_valid, 1);
        checkOutput("rd_rsp_rdata", b0.rsp_rdata, 8'hA5);
        checkOutput("rd_rsp_err", b0.rsp_err, 0);
        tick();
        checkOutput("rd_rsp_valid_drop", b0.rsp_valid, 0);
        checkOutput("rd_rsp_rdata_hold", b0.rsp_rdata, 8'hA5);

        // Back-to-back writes with cmd_valid held high
        applyStimulus(1, 1, 2'd0, 8'h11);
        b0.pready = 1;
        tick();
        applyStimulus(1, 1, 2'd1, 8'h22);
        checkOutput("b2b_setup1_pwdata", b0.pwdata, 8'h11);
        checkOutput("b2b_setup1_ready", b0.cmd_ready, 0);
        tick();
        checkOutput("b2b_access1_ready", b0.cmd_ready, 0);
        tick();
        checkOutput("b2b_idle_rsp_valid", b0.rsp_valid, 1);
        checkOutput("b2b_idle_psel", b0.psel_x, 0);
        checkOutput("b2b_idle_ready", b0.cmd_ready, 1);
        checkOutput("b2b_idle_pwdata", b0.pwdata, 8'h11);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("b2b_setup2_psel", b0.psel_x, 1);
        checkOutput("b2b_setup2_pwdata", b0.pwdata, 8'h22);
        checkOutput("b2b_setup2_paddr", b0.paddr, 1);
        checkOutput("b2b_setup2_rsp_valid", b0.rsp_valid, 0);
        tick();
        tick();
        checkOutput("b2b_rsp2_valid", b0.rsp_valid, 1);
        b0.pready = 0;
        tick();

        // Timeout on the TIMEOUT=4 instance
        b4.cmd_valid = 1; b4.cmd_write = 0; b4.cmd_addr = 2'd3; b4.prdata = 8'h5A;
        tick();
        b4.cmd_valid = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("tmo_access%0d_penable", i), b4.penable, 1);
            tick();
        end
        checkOutput("tmo_psel", b4.psel_x, 0);
        checkOutput("tmo_rsp_valid", b4.rsp_valid, 1);
        checkOutput("tmo_rsp_err", b4.rsp_err, 1);
        checkOutput("tmo_rsp_rdata", b4.rsp_rdata, 0);
        tick();
        checkOutput("tmo_err_hold", b4.rsp_err, 1);

        // Tie on the TIMEOUT=2 instance: pready in the 2nd ACCESS cycle
        b2.cmd_valid = 1; b2.cmd_write = 0; b2.cmd_addr = 2'd2;
        tick();
        b2.cmd_valid = 0;
        tick();
        checkOutput("tie_access1_penable", b2.penable, 1);
        tick();
        checkOutput("tie_access2_penable", b2.penable, 1);
        b2.pready = 1;
        b2.prdata = 8'h3C;
        tick();
        b2.pready = 0;
        checkOutput("tie_rsp_valid", b2.rsp_valid, 1);
        checkOutput("tie_rsp_err", b2.rsp_err, 0);
        checkOutput("tie_rsp_rdata", b2.rsp_rdata, 8'h3C);

        // Asynchronous reset in the middle of ACCESS
        applyStimulus(1, 1, 2'd3, 8'h77);
        tick();
        applyStimulus(0, 0, 0, 0);
        tick();
        checkOutput("arst_pre_penable", b0.penable, 1);
        #2;
        preset_n = 1'b0;
        #1;
        checkOutput("arst_psel", b0.psel_x, 0);
        checkOutput("arst_penable", b0.penable, 0);
        checkOutput("arst_pwdata", b0.pwdata, 0);
        checkOutput("arst_rsp_valid", b0.rsp_valid, 0);
        @(negedge pclk);
        @(negedge pclk);
        preset_n = 1'b1;
        tick();
        checkOutput("arst_after_ready", b0.cmd_ready, 1);
        checkOutput("arst_after_rsp_valid", b0.rsp_valid, 0);
        tick();
        checkOutput("arst_after2_rsp_valid", b0.rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
